// File: rtl/pc_pkg.sv
// Shared types for the program-counter / fetch controller: FSM states,
// redirect-source codes and the default sequential increment.
package pc_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    // Source of a redirect. SRC_SEQ also means "no redirect requested".
    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_JALR,
        SRC_TRAP
    } redir_src_t;

    localparam int DEFAULT_ILEN = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: target adders, redirect priority mux and the
// misaligned-target check that swaps a bad target for the trap vector.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h100,
    parameter int              ILEN     = DEFAULT_ILEN
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_imm_i,
    input  logic            jalr_en_i,
    input  logic [XLEN-1:0] jalr_base_i,
    input  logic [XLEN-1:0] jalr_imm_i,
    input  logic            trap_en_i,
    input  logic            pend_valid_i,
    input  logic [XLEN-1:0] pend_pc_i,
    input  redir_src_t      pend_src_i,
    output redir_src_t      redir_src_o,
    output logic [XLEN-1:0] redir_pc_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] JALR_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] jalr_pc;
    redir_src_t      sel_src;
    logic [XLEN-1:0] sel_pc;

    assign seq_pc  = pc_i + XLEN'(ILEN);
    assign br_pc   = pc_i + br_imm_i;
    assign jalr_pc = (jalr_base_i + jalr_imm_i) & JALR_MASK;

    // Live redirects first; a pending one only fills in for plain sequential flow.
    always_comb begin
        redir_src_o = SRC_SEQ;
        redir_pc_o  = seq_pc;
        if (trap_en_i) begin
            redir_src_o = SRC_TRAP;
            redir_pc_o  = TRAP_VEC;
        end else if (jalr_en_i) begin
            redir_src_o = SRC_JALR;
            redir_pc_o  = jalr_pc;
        end else if (br_taken_i) begin
            redir_src_o = SRC_BR;
            redir_pc_o  = br_pc;
        end

        sel_src = redir_src_o;
        sel_pc  = redir_pc_o;
        if (redir_src_o == SRC_SEQ && pend_valid_i) begin
            sel_src = pend_src_i;
            sel_pc  = pend_pc_i;
        end

        misalign_o = (sel_src != SRC_TRAP) && (sel_pc[1:0] != 2'b00);
        next_pc_o  = misalign_o ? TRAP_VEC : sel_pc;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch controller with a req/ack I-mem
// handshake, stall support and redirects latched across wait states.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h100,
    parameter int              ILEN      = DEFAULT_ILEN
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_imm,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_base,
    input  logic [XLEN-1:0] jalr_imm,
    input  logic            trap_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misalign_err
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    redir_src_t      pend_src_q, pend_src_d;
    logic            pend_valid_q, pend_valid_d;
    logic            misalign_err_q, misalign_err_d;

    redir_src_t      redir_src;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] next_pc;
    logic            misalign;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .ILEN     (ILEN)
    ) u_next_sel (
        .pc_i         (pc_q),
        .br_taken_i   (br_taken),
        .br_imm_i     (br_imm),
        .jalr_en_i    (jalr_en),
        .jalr_base_i  (jalr_base),
        .jalr_imm_i   (jalr_imm),
        .trap_en_i    (trap_en),
        .pend_valid_i (pend_valid_q),
        .pend_pc_i    (pend_pc_q),
        .pend_src_i   (pend_src_q),
        .redir_src_o  (redir_src),
        .redir_pc_o   (redir_pc),
        .next_pc_o    (next_pc),
        .misalign_o   (misalign)
    );

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_VEC;
            hold_pc_q      <= RESET_VEC;
            pend_pc_q      <= RESET_VEC;
            pend_src_q     <= SRC_SEQ;
            pend_valid_q   <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            hold_pc_q      <= hold_pc_d;
            pend_pc_q      <= pend_pc_d;
            pend_src_q     <= pend_src_d;
            pend_valid_q   <= pend_valid_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // An accepted ack consumes (or supersedes) any pending redirect; a
    // redirect seen in any other non-boot cycle is remembered, latest wins.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_pc_d      = hold_pc_q;
        pend_pc_d      = pend_pc_q;
        pend_src_d     = pend_src_q;
        pend_valid_d   = pend_valid_q;
        misalign_err_d = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    misalign_err_d = misalign;
                    pend_valid_d   = 1'b0;
                    if (stall) begin
                        hold_pc_d = next_pc;
                        state_d   = S_HOLD;
                    end else begin
                        pc_d = next_pc;
                    end
                end else if (redir_src != SRC_SEQ) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_pc;
                    pend_src_d   = redir_src;
                end
            end
            S_HOLD: begin
                if (redir_src != SRC_SEQ) begin
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_pc;
                    pend_src_d   = redir_src;
                end
                if (!stall) begin
                    pc_d    = hold_pc_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign pc_valid     = (state_q == S_FETCH) && imem_ack;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl: sequential fetch, branches, JALR
// misalignment, pending redirects, stall and mid-fetch reset.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        areset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_imm;
    logic        jalr_en;
    logic [31:0] jalr_base;
    logic [31:0] jalr_imm;
    logic        trap_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misalign_err;

    int total;
    int bad;

    pc_fetch_ctrl dut (
        .clk          (clk),
        .areset       (areset),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_imm       (br_imm),
        .jalr_en      (jalr_en),
        .jalr_base    (jalr_base),
        .jalr_imm     (jalr_imm),
        .trap_en      (trap_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_imm    = 32'h0;
        jalr_en   = 1'b0;
        jalr_base = 32'h0;
        jalr_imm  = 32'h0;
        trap_en   = 1'b0;
        imem_ack  = 1'b0;
    endtask

    // Jump to an aligned address with an acknowledged JALR.
    task automatic goto(input logic [31:0] addr);
        jalr_en   = 1'b1;
        jalr_base = addr;
        jalr_imm  = 32'h0;
        imem_ack  = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        areset = 1'b0;
        clear_inputs();
        tick();
        tick();
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign_err); end
        areset = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL boot_req got=%b exp=0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL fetch_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        imem_ack = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (pc !== 32'(4 * i)) begin bad++; $display("[TB] FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
            total++; if (pc_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid%0d got=%b exp=1", i, pc_valid); end
            total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("[TB] FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, 32'(4 * i)); end
            tick();
        end
        clear_inputs();
        total++; if (pc !== 32'hC) begin bad++; $display("[TB] FAIL seq_end got=%h exp=%h", pc, 32'hC); end
    endtask

    task automatic test_branch();
        goto(32'h40);
        total++; if (pc !== 32'h40) begin bad++; $display("[TB] FAIL goto40 got=%h exp=%h", pc, 32'h40); end
        br_taken = 1'b1;
        br_imm   = 32'hFFFF_FFF8;
        imem_ack = 1'b1;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h38) begin bad++; $display("[TB] FAIL br_back got=%h exp=%h", pc, 32'h38); end
        goto(32'hFFFF_FFFC);
        total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL goto_top got=%h exp=%h", pc, 32'hFFFF_FFFC); end
        imem_ack = 1'b1;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap got=%h exp=%h", pc, 32'h0); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err got=%b exp=0", misalign_err); end
    endtask

    task automatic test_misalign();
        jalr_en   = 1'b1;
        jalr_base = 32'h101;
        jalr_imm  = 32'h2;
        imem_ack  = 1'b1;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h100) begin bad++; $display("[TB] FAIL mis_pc got=%h exp=%h", pc, 32'h100); end
        total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL mis_err got=%b exp=1", misalign_err); end
        tick();
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL mis_pulse got=%b exp=0", misalign_err); end
        total++; if (pc !== 32'h100) begin bad++; $display("[TB] FAIL mis_hold got=%h exp=%h", pc, 32'h100); end
        goto(32'h104);
        jalr_en   = 1'b1;
        jalr_base = 32'h201;
        jalr_imm  = 32'h0;
        imem_ack  = 1'b1;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h200) begin bad++; $display("[TB] FAIL jalr_lsb got=%h exp=%h", pc, 32'h200); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL jalr_lsb_err got=%b exp=0", misalign_err); end
    endtask

    task automatic test_trap_priority();
        trap_en   = 1'b1;
        jalr_en   = 1'b1;
        jalr_base = 32'h101;
        jalr_imm  = 32'h2;
        imem_ack  = 1'b1;
        tick();
        clear_inputs();
        total++; if (pc !== 32'h100) begin bad++; $display("[TB] FAIL trap_pc got=%h exp=%h", pc, 32'h100); end
        total++; if (misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL trap_err got=%b exp=0", misalign_err); end
    endtask

    task automatic test_pending();
        goto(32'h20);
        br_taken = 1'b1;
        br_imm   = 32'h10;
        #1;
        total++; if (pc_valid !== 1'b0) begin bad++; $display("[TB] FAIL pend_valid_wait got=%b exp=0", pc_valid); end
        tick();
        clear_inputs();
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL pend_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h20) begin bad++; $display("[TB] FAIL pend_addr got=%h exp=%h", imem_addr, 32'h20); end
        tick();
        imem_ack = 1'b1;
        tick();
        total++; if (pc !== 32'h30) begin bad++; $display("[TB] FAIL pend_pc got=%h exp=%h", pc, 32'h30); end
        tick();
        clear_inputs();
        total++; if (pc !== 32'h34) begin bad++; $display("[TB] FAIL pend_clear got=%h exp=%h", pc, 32'h34); end
    endtask

    task automatic test_stall();
        goto(32'h8);
        stall    = 1'b1;
        imem_ack = 1'b1;
        #1;
        total++; if (pc_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_retire got=%b exp=1", pc_valid); end
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (pc !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc%0d got=%h exp=%h", i, pc, 32'h8); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req%0d got=%b exp=0", i, imem_req); end
            tick();
        end
        stall = 1'b0;
        tick();
        total++; if (pc !== 32'hC) begin bad++; $display("[TB] FAIL release_pc got=%h exp=%h", pc, 32'hC); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL release_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_reset_midfetch();
        goto(32'h50);
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_req got=%b exp=1", imem_req); end
        areset = 1'b0;
        #2;
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL mid_rst_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_req got=%b exp=0", imem_req); end
        tick();
        areset   = 1'b1;
        imem_ack = 1'b1;
        #1;
        total++; if (pc_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_ack got=%b exp=0", pc_valid); end
        tick();
        imem_ack = 1'b0;
        total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL boot_ack_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL boot_done_req got=%b exp=1", imem_req); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_misalign();
        test_trap_priority();
        test_pending();
        test_stall();
        test_reset_midfetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
